seg_bus_decoder: RTL and testbench
==================================

// Module: seg_bus_decoder
// PURPOSE
// - Receive end of the 7-segment display bus: samples a multiplexed, active-low digit/segment bus
//   (as driven by the BCD-to-segment encoder plus scan driver) and rebuilds the BCD value per digit.
// - Used as an on-board display monitor and as a self-check block in display-path benches.
// PARAMETERS
// - NUM_DIG     8   number of multiplexed digits (2..8)
// - STABLE_CYC  4   consecutive identical samples needed to commit a digit (2..255)
// PORTS
// - clk        in   1            system clock, all logic rising-edge
// - rst        in   1            asynchronous, active-high reset
// - an_n       in   NUM_DIG      digit enables, active low, one-hot-low when valid
// - seg_n      in   8            {dp,g,f,e,d,c,b,a}, active low
// - err_clr    in   1            clears anode_err
// - digits     out  4*NUM_DIG    decoded value per digit, digit i at [4i+3:4i]
// - dig_valid  out  NUM_DIG      digit i committed at least once since reset
// - upd        out  1            one-cycle pulse per commit
// - upd_idx    out  3            index of digit committed with upd
// - frame_done out  1            one-cycle pulse when every digit committed since last frame
// - anode_err  out  1            sticky: more than one an_n bit low seen on a stable sample
// - dp_out     out  NUM_DIG      decimal point per digit, 1 = lit (see CONFIGURATION)
// BEHAVIOUR
// - Reset: digits all 4'hF, dig_valid 0, upd 0, upd_idx 0, frame_done 0, anode_err 0, dp_out 0,
//   seen mask 0, stable counter 0, sync/sample registers all ones (bus idle).
// - Inputs pass a 2-flop synchronizer; sample S = {an_n, seg_n} taken from second stage.
// - Stable counter: S equal to previous S -> saturating increment; S changed -> counter 0.
// - Commit when counter reaches STABLE_CYC-1 (STABLE_CYC identical samples) and an_n has exactly
//   one low bit; exactly one commit per stable window; no re-commit until S changes.
// - an_n all high: blanking interval, never commits, no error.
// - an_n two or more low at the commit point: no commit, anode_err <= 1; err_clr clears it;
//   set and err_clr in the same cycle -> set wins.
// - Decode of seg_n[6:0] (g..a): 40->0 79->1 24->2 30->3 19->4 12->5 02->6 78->7 00->8 10->9;
//   7F (blank) -> 4'hF; any other pattern -> 4'hE. dp ignored by decode.
// - Commit cycle N: digits slot, dig_valid bit, upd=1, upd_idx = position of low an_n bit, all
//   registered at edge N+1. Latency from bus change to upd: 2 (sync) + STABLE_CYC cycles.
// - Frame: seen |= committed bit; when seen becomes all ones, frame_done pulses with that upd and
//   seen clears in the same edge. Re-committing an already-seen digit does not pulse.
// - Glitch shorter than STABLE_CYC samples: counter restarts, no commit, outputs unchanged.
// - Reset mid-window: all state returns to reset values immediately; counting restarts from 0.
// CONFIGURATION
// - SEG_DP_CAPTURE_EN defined: on commit, dp_out[idx] <= ~seg_n[7].
// - Not defined: dp_out tied 0; dp bit still part of S, so dp change restarts the stable counter.
// TESTING
// - Reset, idle bus (all ones) 100 cycles -> no upd, digits all F, dig_valid 0, anode_err 0.
// - an_n=8'hFE, seg_n=8'hC0 held 10 cycles -> one upd at 2+4 cycles, upd_idx 0, digits[3:0]=0.
// - Scan 8 digits showing 1..8 (codes 79,24,30,19,12,02,78,00), 8 cycles each -> 8 upd,
//   frame_done pulses on 8th, digits = 32'h8765_4321, dig_valid = 8'hFF.
// - an_n=8'hFD, seg_n alternating 79/24 every 3 cycles -> no upd; then seg_n=8'hF9 held -> value 1.
// - an_n=8'hFC held 6 cycles -> anode_err=1, no upd; err_clr same cycle as new error -> stays 1.
// - SEG_DP_CAPTURE_EN: an_n=8'hF7, seg_n=8'h10 -> digits[15:12]=9, dp_out[3]=1; seg_n=8'h7F -> F.

Source files
------------

// File: rtl/seg_bus_decoder.sv
// rtl/seg_bus_decoder.sv - receive side of the multiplexed 7-segment bus, rebuilds per-digit BCD
// Optional feature macro: SEG_DP_CAPTURE_EN (decimal point capture into dp_out)
module seg_bus_decoder #(
   parameter int NUM_DIG    = 8,
   parameter int STABLE_CYC = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_DIG-1:0]     an_n,
   input  logic [7:0]             seg_n,
   input  logic                   err_clr,
   output logic [4*NUM_DIG-1:0]   digits,
   output logic [NUM_DIG-1:0]     dig_valid,
   output logic                   upd,
   output logic [2:0]             upd_idx,
   output logic                   frame_done,
   output logic                   anode_err,
   output logic [NUM_DIG-1:0]     dp_out
);

   // Sample word is {an_n, seg_n}; a change anywhere restarts the stability window.
   localparam int SW = NUM_DIG + 8;
   localparam logic [7:0] CNT_MAX = 8'(STABLE_CYC - 1);
   localparam logic [7:0] CNT_PRE = 8'(STABLE_CYC - 2);

   // Synchronizer and stability tracking state
   logic [SW-1:0]          sync1_q;
   logic [SW-1:0]          sync2_q;
   logic [SW-1:0]          prev_q;
   logic [7:0]             cnt_q, cnt_d;

   // Architectural output state
   logic [4*NUM_DIG-1:0]   digits_q, digits_d;
   logic [NUM_DIG-1:0]     valid_q, valid_d;
   logic [NUM_DIG-1:0]     seen_q, seen_d;
   logic                   upd_q, upd_d;
   logic [2:0]             idx_q, idx_d;
   logic                   frame_q, frame_d;
   logic                   err_q, err_d;

   logic [SW-1:0]          sample;
   logic [NUM_DIG-1:0]     an_s;
   logic                   same;
   logic                   window_hit;
   logic [3:0]             low_cnt;
   logic [2:0]             low_idx;
   logic                   commit;
   logic                   multi_low;
   logic [3:0]             dec_val;
   logic [NUM_DIG-1:0]     hit_mask;
   logic [NUM_DIG-1:0]     seen_or;

   // Number of asserted (low) anode enables
   function automatic logic [3:0] count_low(input logic [NUM_DIG-1:0] an);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < NUM_DIG; i++) begin
         if (!an[i]) n = n + 4'd1;
      end
      return n;
   endfunction

   // Position of the low anode enable (meaningful only when exactly one is low)
   function automatic logic [2:0] find_low(input logic [NUM_DIG-1:0] an);
      logic [2:0] p;
      p = '0;
      for (int i = 0; i < NUM_DIG; i++) begin
         if (!an[i]) p = 3'(i);
      end
      return p;
   endfunction

   // Inverse of the BCD-to-segment encoder; blank maps to F, anything unknown to E
   function automatic logic [3:0] decode_seg(input logic [6:0] s);
      logic [3:0] v;
      case (s)
         7'h40:   v = 4'h0;
         7'h79:   v = 4'h1;
         7'h24:   v = 4'h2;
         7'h30:   v = 4'h3;
         7'h19:   v = 4'h4;
         7'h12:   v = 4'h5;
         7'h02:   v = 4'h6;
         7'h78:   v = 4'h7;
         7'h00:   v = 4'h8;
         7'h10:   v = 4'h9;
         7'h7F:   v = 4'hF;
         default: v = 4'hE;
      endcase
      return v;
   endfunction

   assign sample  = sync2_q;
   assign an_s    = sample[SW-1:8];
   assign same    = (sample == prev_q);
   assign low_cnt = count_low(an_s);
   assign low_idx = find_low(an_s);
   assign dec_val = decode_seg(sample[6:0]);

   // The window is hit exactly once: on the sample that takes the counter to CNT_MAX.
   // Afterwards the counter saturates, so a steady bus never re-commits.
   assign window_hit = same && (cnt_q == CNT_PRE);
   assign commit     = window_hit && (low_cnt == 4'd1);
   assign multi_low  = window_hit && (low_cnt >= 4'd2);
   assign hit_mask   = commit ? ~an_s : '0;
   assign seen_or    = seen_q | hit_mask;

   // Saturating stability counter; any difference between samples restarts it
   always_comb begin
      cnt_d = '0;
      if (same) begin
         cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 8'd1;
      end
   end

   // Next-state for decoded digits, valid flags, frame tracking and the anode error flag
   always_comb begin
      digits_d = digits_q;
      valid_d  = valid_q;
      seen_d   = seen_q;
      upd_d    = commit;
      idx_d    = idx_q;
      frame_d  = 1'b0;
      err_d    = err_q;
      if (err_clr) begin
         err_d = 1'b0;
      end
      if (multi_low) begin
         err_d = 1'b1;
      end
      if (commit) begin
         idx_d   = low_idx;
         valid_d = valid_q | hit_mask;
         for (int i = 0; i < NUM_DIG; i++) begin
            if (hit_mask[i]) digits_d[4*i +: 4] = dec_val;
         end
         if (&seen_or) begin
            frame_d = 1'b1;
            seen_d  = '0;
         end else begin
            seen_d  = seen_or;
         end
      end
   end

   // Two-flop synchronizer plus previous-sample register; idle bus is all ones
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= '1;
         sync2_q <= '1;
         prev_q  <= '1;
         cnt_q   <= '0;
      end else begin
         sync1_q <= {an_n, seg_n};
         sync2_q <= sync1_q;
         prev_q  <= sample;
         cnt_q   <= cnt_d;
      end
   end

   // Registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         digits_q <= '1;
         valid_q  <= '0;
         seen_q   <= '0;
         upd_q    <= 1'b0;
         idx_q    <= '0;
         frame_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         digits_q <= digits_d;
         valid_q  <= valid_d;
         seen_q   <= seen_d;
         upd_q    <= upd_d;
         idx_q    <= idx_d;
         frame_q  <= frame_d;
         err_q    <= err_d;
      end
   end

`ifdef SEG_DP_CAPTURE_EN
   logic [NUM_DIG-1:0] dp_q;

   // Capture the decimal point of the committed digit (seg_n[7] is active low)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dp_q <= '0;
      end else begin
         for (int i = 0; i < NUM_DIG; i++) begin
            if (hit_mask[i]) dp_q[i] <= ~sample[7];
         end
      end
   end

   assign dp_out = dp_q;
`else
   assign dp_out = '0;
`endif

   assign digits     = digits_q;
   assign dig_valid  = valid_q;
   assign upd        = upd_q;
   assign upd_idx    = idx_q;
   assign frame_done = frame_q;
   assign anode_err  = err_q;

endmodule

// File: tb/tb_seg_bus_decoder.sv
// tb/tb_seg_bus_decoder.sv - table-driven bench for seg_bus_decoder
module tb_seg_bus_decoder;
   localparam int ND = 8;
`ifdef SEG_DP_CAPTURE_EN
   localparam logic DP_EN = 1'b1;
`else
   localparam logic DP_EN = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst;
   logic [ND-1:0]   an_n;
   logic [7:0]      seg_n;
   logic            err_clr;
   logic [4*ND-1:0] digits;
   logic [ND-1:0]   dig_valid;
   logic            upd;
   logic [2:0]      upd_idx;
   logic            frame_done;
   logic            anode_err;
   logic [ND-1:0]   dp_out;

   always #5 clk = ~clk;

   seg_bus_decoder #(.NUM_DIG(ND), .STABLE_CYC(4)) dut (
      .clk(clk), .rst(rst), .an_n(an_n), .seg_n(seg_n), .err_clr(err_clr),
      .digits(digits), .dig_valid(dig_valid), .upd(upd), .upd_idx(upd_idx),
      .frame_done(frame_done), .anode_err(anode_err), .dp_out(dp_out)
   );

   typedef struct {
      logic [7:0] an;
      logic [7:0] seg;
      int         hold;
      int         n_upd;
      int         idx;
      logic [3:0] nib;
      int         n_frame;
      logic       dp;
   } vec_t;

   vec_t vt[15];
   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Hold current inputs for n cycles, recording upd/frame_done activity
   task automatic hold(input int n, output int nu, output int first, output int nf,
                       output logic [2:0] lidx);
      nu = 0; first = -1; nf = 0; lidx = '0;
      for (int k = 1; k <= n; k++) begin
         tick();
         if (upd) begin
            nu++;
            if (first < 0) first = k;
            lidx = upd_idx;
         end
         if (frame_done) nf++;
      end
   endtask

   initial begin
      int nu, first, nf;
      logic [2:0] lidx;
      logic [7:0] codes [8];
      logic [7:0] alt;

      codes = '{8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80};
      vt[0] = '{8'hFE, 8'hC0, 10, 1, 0, 4'h0, 0, 1'b0};
      for (int i = 0; i < 8; i++) begin
         vt[1+i] = '{~(8'd1 << i), codes[i], 8, 1, i, 4'(i+1), (i == 7) ? 1 : 0, 1'b0};
      end
      vt[9]  = '{8'hFF, 8'hC0, 10, 0, 0, 4'h1, 0, 1'b0};
      vt[10] = '{8'hFE, 8'hFF, 10, 1, 0, 4'hF, 0, 1'b0};
      vt[11] = '{8'hFE, 8'hAA, 10, 1, 0, 4'hE, 0, 1'b0};
      vt[12] = '{8'hF7, 8'h10, 10, 1, 3, 4'h9, 0, DP_EN};
      vt[13] = '{8'hF7, 8'h7F, 10, 1, 3, 4'hF, 0, DP_EN};
      vt[14] = '{8'hFE, 8'h40, 10, 1, 0, 4'h0, 0, DP_EN};

      rst = 1'b1; an_n = '1; seg_n = '1; err_clr = 1'b0;
      tick(); tick();
      chk("reset_digits", 64'(digits), 64'hFFFF_FFFF);
      chk("reset_valid", 64'(dig_valid), 64'h0);
      chk("reset_upd", 64'(upd), 64'h0);
      chk("reset_frame", 64'(frame_done), 64'h0);
      chk("reset_err", 64'(anode_err), 64'h0);
      chk("reset_dp", 64'(dp_out), 64'h0);
      rst = 1'b0;

      hold(100, nu, first, nf, lidx);
      chk("idle_upd_count", 64'(nu), 64'd0);
      chk("idle_digits", 64'(digits), 64'hFFFF_FFFF);
      chk("idle_valid", 64'(dig_valid), 64'h0);
      chk("idle_err", 64'(anode_err), 64'h0);

      for (int r = 0; r < 15; r++) begin
         an_n = vt[r].an; seg_n = vt[r].seg;
         hold(vt[r].hold, nu, first, nf, lidx);
         chk($sformatf("v%0d_upd_count", r), 64'(nu), 64'(vt[r].n_upd));
         chk($sformatf("v%0d_frame", r), 64'(nf), 64'(vt[r].n_frame));
         chk($sformatf("v%0d_nibble", r), 64'(digits[4*vt[r].idx +: 4]), 64'(vt[r].nib));
         chk($sformatf("v%0d_dp", r), 64'(dp_out[vt[r].idx]), 64'(vt[r].dp));
         if (vt[r].n_upd > 0) begin
            chk($sformatf("v%0d_latency", r), 64'(first), 64'd6);
            chk($sformatf("v%0d_idx", r), 64'(lidx), 64'(vt[r].idx));
         end
         if (r == 8) begin
            chk("scan_digits", 64'(digits), 64'h8765_4321);
            chk("scan_valid", 64'(dig_valid), 64'hFF);
         end
      end
      chk("table_digits", 64'(digits), 64'h8765_F320);
      chk("table_dp", 64'(dp_out), DP_EN ? 64'h09 : 64'h00);
      chk("table_err", 64'(anode_err), 64'h0);

      // Glitching segment pattern never stays long enough to commit
      an_n = 8'hFD;
      alt = 8'hF9;
      for (int g = 0; g < 8; g++) begin
         seg_n = alt;
         hold(3, nu, first, nf, lidx);
         chk($sformatf("glitch%0d_upd", g), 64'(nu), 64'd0);
         alt = (alt == 8'hF9) ? 8'hA4 : 8'hF9;
      end
      chk("glitch_digit1", 64'(digits[7:4]), 64'h2);
      seg_n = 8'hF9;
      hold(10, nu, first, nf, lidx);
      chk("post_glitch_upd", 64'(nu), 64'd1);
      chk("post_glitch_idx", 64'(lidx), 64'd1);
      chk("post_glitch_digit1", 64'(digits[7:4]), 64'h1);

      // Two anodes low: error, no commit; clear; set wins over simultaneous clear
      an_n = 8'hFC; seg_n = 8'hC0;
      hold(6, nu, first, nf, lidx);
      chk("multi_upd", 64'(nu), 64'd0);
      chk("multi_err_set", 64'(anode_err), 64'h1);
      err_clr = 1'b1;
      tick();
      chk("err_cleared", 64'(anode_err), 64'h0);
      an_n = 8'hF3;
      hold(6, nu, first, nf, lidx);
      chk("multi2_upd", 64'(nu), 64'd0);
      chk("err_set_wins", 64'(anode_err), 64'h1);
      err_clr = 1'b0;
      tick();
      chk("err_sticky", 64'(anode_err), 64'h1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("err_cleared2", 64'(anode_err), 64'h0);

      // Reset in the middle of a stability window
      an_n = 8'hFB; seg_n = 8'h92;
      hold(3, nu, first, nf, lidx);
      chk("prereset_upd", 64'(nu), 64'd0);
      rst = 1'b1;
      #1;
      chk("midrst_digits", 64'(digits), 64'hFFFF_FFFF);
      chk("midrst_valid", 64'(dig_valid), 64'h0);
      chk("midrst_idx", 64'(upd_idx), 64'h0);
      chk("midrst_dp", 64'(dp_out), 64'h0);
      tick();
      rst = 1'b0;
      hold(10, nu, first, nf, lidx);
      chk("postrst_upd", 64'(nu), 64'd1);
      chk("postrst_latency", 64'(first), 64'd6);
      chk("postrst_idx", 64'(lidx), 64'd2);
      chk("postrst_digit2", 64'(digits[11:8]), 64'h5);
      chk("postrst_valid", 64'(dig_valid), 64'h04);
      chk("postrst_frame", 64'(nf), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
